// File: rtl/bist_ctrl_c12.sv
// BIST controller around the circuito12 J/K sync detector: LFSR stimulus, MISR compaction.
// Define BIST_SIG_OUT_EN to expose the MISR signature on bist_sig.
module bist_ctrl_c12 #(
    parameter int unsigned N_PATTERNS = 200,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned CUT_LAT    = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'h01,
    parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bist_start,
    input  logic       func_rst,
    input  logic       func_k,
    input  logic       func_j,
    input  logic       func_rx_en,
    output logic       cut_rst,
    output logic       cut_k,
    output logic       cut_j,
    output logic       cut_rx_en,
    input  logic       cut_synced,
    input  logic       cut_err,
`ifdef BIST_SIG_OUT_EN
    output logic [7:0] bist_sig,
`endif
    output logic       bist_busy,
    output logic       bist_done,
    output logic       bist_pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_CUT,
        S_RUN,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST = 32'(N_PATTERNS + CUT_LAT - 1);
    localparam logic [31:0] ADV_LAST = 32'(N_PATTERNS - 1);
    localparam logic [31:0] CAP_FIRST = 32'(CUT_LAT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  misr_q, misr_d;
    logic        pass_q, pass_d;
    logic [15:0] cnt_inc;
    logic [31:0] cnt32;

    // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    function automatic logic [7:0] step8(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign cnt32   = {16'd0, cnt_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        pass_d    = pass_q;
        cut_rst   = func_rst;
        cut_k     = func_k;
        cut_j     = func_j;
        cut_rx_en = func_rx_en;
        bist_busy = 1'b0;
        bist_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bist_start) begin
                    state_d = S_RESET_CUT;
                    cnt_d   = 16'd0;
                end
            end
            S_RESET_CUT: begin
                bist_busy = 1'b1;
                cut_rst   = 1'b1;
                cut_k     = 1'b0;
                cut_j     = 1'b0;
                cut_rx_en = 1'b0;
                lfsr_d    = LFSR_SEED;
                misr_d    = 8'h00;
                pass_d    = 1'b0;
                if (cnt32 == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                bist_busy = 1'b1;
                cut_rst   = 1'b0;
                {cut_k, cut_j, cut_rx_en} = lfsr_q[2:0];
                // stop one short so the last vector stays on the CUT
                if (cnt32 < ADV_LAST) begin
                    lfsr_d = step8(lfsr_q);
                end
                if (cnt32 >= CAP_FIRST) begin
                    misr_d = step8(misr_q) ^ {6'b0, cut_err, cut_synced};
                end
                if (cnt32 == RUN_LAST) begin
                    state_d = S_COMPARE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_COMPARE: begin
                bist_busy = 1'b1;
                cut_rst   = 1'b0;
                {cut_k, cut_j, cut_rx_en} = lfsr_q[2:0];
                pass_d    = (misr_q == GOLDEN_SIG);
                state_d   = S_DONE;
            end
            S_DONE: begin
                bist_done = 1'b1;
                if (!bist_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bist_pass = pass_q;
`ifdef BIST_SIG_OUT_EN
    assign bist_sig = misr_q;
`endif

endmodule
